// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush and memory-freeze pipeline control; HAZARD_PERF_EN adds stall/flush counters
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_if_id,
  input  logic [4:0] rt_if_id,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic       mem_rd_id_ex,
  input  logic [4:0] wr_num_id_ex,
  input  logic       branch_taken_ex,
  input  logic       dm_req,
  input  logic       dm_ack,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       if_id_flush,
  output logic       id_ex_we,
  output logic       id_ex_bubble,
  output logic       ex_mem_we,
  output logic       mem_wb_bubble,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic lu, frz, brf;
  always_comb begin
    lu = mem_rd_id_ex && wr_num_id_ex != 5'd0 &&
         ((uses_rs && rs_if_id == wr_num_id_ex) || (uses_rt && rt_if_id == wr_num_id_ex));
    frz = state == ERR || (state == RUN && dm_req && !dm_ack) || (state == MEM_WAIT && !dm_ack);
    brf = !frz && branch_taken_ex;
    pc_we = !rst && !frz && (brf || !lu);
    if_id_we = !rst && !frz && (brf || !lu);
    id_ex_we = !rst && !frz;
    ex_mem_we = !rst && !frz;
    if_id_flush = rst || brf;
    id_ex_bubble = rst || brf || (!frz && lu);
    mem_wb_bubble = rst || frz;
    mem_err = !rst && state == ERR;
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == RUN && dm_req && !dm_ack) begin
      state_nxt = MEM_WAIT;
      cnt_nxt = CW'(1);
    end else if (state == MEM_WAIT && dm_ack) begin
      state_nxt = RUN;
    end else if (state == MEM_WAIT) begin
      if (cnt == CW'(MEM_TIMEOUT)) state_nxt = ERR;
      else cnt_nxt = cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, frz || (lu && !brf)};
      flush_count <= flush_count + {31'd0, brf};
    end
  end
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It watches the ID, EX and MEM stages and drives the write-enable, bubble and flush controls of the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers. It resolves three hazard classes:
- load-use hazards, with a one-cycle bubble;
- taken branches, by squashing IF/ID and ID/EX;
- multi-cycle data-memory accesses, by freezing the pipe with a timeout watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before a memory error is declared (≥1).

Ports:
- clk  in  1  rising-edge clock, one clock domain
- rst  in  1  asynchronous, active-high reset
- rs_if_id  in  5  rs field of instruction in ID
- rt_if_id  in  5  rt field of instruction in ID
- uses_rs  in  1  ID instruction reads rs
- uses_rt  in  1  ID instruction reads rt
- mem_rd_id_ex  in  1  instruction in EX is a load
- wr_num_id_ex  in  5  destination register of instruction in EX
- branch_taken_ex  in  1  branch/jump in EX resolved taken
- dm_req  in  1  MEM-stage instruction accesses data memory
- dm_ack  in  1  data memory completes access this cycle
- pc_we  out  1  pc register load enable
- if_id_we  out  1  IF/ID capture enable
- if_id_flush  out  1  IF/ID captures NOP
- id_ex_we  out  1  ID/EX capture enable
- id_ex_bubble  out  1  ID/EX captures NOP (all control fields zeroed: wr_en_reg=0, dm_rw=0)
- ex_mem_we  out  1  EX/MEM capture enable
- mem_wb_bubble  out  1  MEM/WB captures NOP
- mem_err  out  1  sticky memory timeout flag
- stall_cycles  out  32  performance counter (HAZARD_PERF_EN only)
- flush_count  out  32  performance counter (HAZARD_PERF_EN only)

## Operation
FSM states: RUN, MEM_WAIT, ERR. Controls are combinational from the state and inputs.

Priority order, highest first: rst, ERR, freeze, branch flush, load-use, normal.
- **rst high:** all `_we`=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, mem_err=0, counters=0. State becomes RUN.
- **Freeze:** applies in RUN when dm_req=1 and dm_ack=0, or in MEM_WAIT when dm_ack=0.
  - pc_we, if_id_we, id_ex_we, ex_mem_we all 0.
  - mem_wb_bubble=1; flush and id_ex_bubble=0.
- **Branch flush:** branch_taken_ex=1 and no freeze.
  - All `_we`=1, if_id_flush=1, id_ex_bubble=1.
  - Any load-use hazard in the same cycle is ignored, because the ID instruction is squashed.
- **Load-use:** mem_rd_id_ex=1, wr_num_id_ex≠0, and either (uses_rs and rs_if_id==wr_num_id_ex) or (uses_rt and rt_if_id==wr_num_id_ex).
  - pc_we=0, if_id_we=0, id_ex_bubble=1, ex_mem_we=1.
  - No state change; the next cycle sees the bubble in EX and proceeds.
- **Normal:** all `_we`=1, all flush/bubble=0.

FSM transitions:
- RUN → MEM_WAIT: dm_req=1 and dm_ack=0. The wait counter loads 1.
- MEM_WAIT → RUN: dm_ack=1. That cycle is not frozen; normal/branch/load-use rules apply.
- MEM_WAIT, dm_ack=0: the counter increments. If the counter equals MEM_TIMEOUT → ERR.
- ERR: permanent freeze with mem_err=1 until rst.
- dm_req=1 with dm_ack=1 in RUN is a single-cycle access and causes no stall.
- The counter width is clog2(MEM_TIMEOUT+1) and it never wraps.

## Timing
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 2 squashed slots.
- A memory wait costs N freeze cycles, where dm_ack arrives N cycles after dm_req first asserts.
- ERR is entered on the edge ending the MEM_TIMEOUT-th MEM_WAIT cycle without ack. mem_err=1 from the following cycle.
- rst asserted mid-MEM_WAIT: state immediately (asynchronously) becomes RUN; counter cleared.
- branch_taken_ex asserted during a freeze is held off by the freeze. It takes effect in the releasing cycle if EX still presents it.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every load-use or freeze cycle, ERR included.
  - flush_count increments on every branch-flush cycle.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by rst.
- HAZARD_PERF_EN undefined: both ports and their counters are absent.

## Test plan
- lw $5 in EX (mem_rd_id_ex=1, wr_num=5), ID reads rs=5 → one cycle with pc_we=0, if_id_we=0, id_ex_bubble=1; the next cycle is normal.
- Same as above but wr_num=0 → no stall.
- branch_taken_ex=1 together with a load-use match → if_id_flush=1, id_ex_bubble=1, pc_we=1; stall_cycles unchanged.
- dm_req=1, dm_ack rises 3 cycles later → 3 freeze cycles (ex_mem_we=0, mem_wb_bubble=1), return to RUN; stall_cycles=3.
- dm_req=1, dm_ack never, MEM_TIMEOUT=4 → ERR after 4 MEM_WAIT cycles; mem_err=1 and all `_we`=0 held until rst.
- rst pulsed during MEM_WAIT → outputs go to reset values immediately; after release, state is RUN and the counters are 0.
